// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: active-low glyph table, capture FSM states
// and the pattern-to-nibble decode used by both the display driver and the capture.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  typedef enum logic {
    COLLECT  = 1'b0,
    COMPLETE = 1'b1
  } cap_state_t;

  typedef struct packed {
    logic       valid;
    logic       blank;
    logic [3:0] nibble;
  } seg_dec_t;

  // Blank decodes as a valid digit with nibble 0; anything off-table is invalid.
  function automatic seg_dec_t seg_to_hex(input logic [6:0] seg);
    seg_dec_t d;
    d.valid  = 1'b1;
    d.blank  = 1'b0;
    d.nibble = 4'h0;
    case (seg)
      GLYPH_0:   d.nibble = 4'h0;
      GLYPH_1:   d.nibble = 4'h1;
      GLYPH_2:   d.nibble = 4'h2;
      GLYPH_3:   d.nibble = 4'h3;
      GLYPH_4:   d.nibble = 4'h4;
      GLYPH_5:   d.nibble = 4'h5;
      GLYPH_6:   d.nibble = 4'h6;
      GLYPH_7:   d.nibble = 4'h7;
      GLYPH_8:   d.nibble = 4'h8;
      GLYPH_9:   d.nibble = 4'h9;
      GLYPH_A:   d.nibble = 4'hA;
      GLYPH_B:   d.nibble = 4'hB;
      GLYPH_C:   d.nibble = 4'hC;
      GLYPH_D:   d.nibble = 4'hD;
      GLYPH_E:   d.nibble = 4'hE;
      GLYPH_F:   d.nibble = 4'hF;
      SEG_BLANK: d.blank  = 1'b1;
      default:   d.valid  = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational segment-pattern decoder: seg -> {valid, blank, nibble}.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output seg_dec_t   dec
);

  assign dec = seg_to_hex(seg);

endmodule

// File: rtl/seven_seg_capture.sv
// Capture side of the multiplexed seven-segment interface: waits for each
// anode dwell to settle, decodes the digit, and publishes complete 4-digit frames.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int FRAME_CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   CA,
  input  logic                   CB,
  input  logic                   CC,
  input  logic                   CD,
  input  logic                   CE,
  input  logic                   CF,
  input  logic                   CG,
  input  logic                   DP,
  input  logic                   AN1,
  input  logic                   AN2,
  input  logic                   AN3,
  input  logic                   AN4,
  output logic [15:0]            captured_value,
  output logic [3:0]             blank_mask,
  output logic [3:0]             dp_mask,
  output logic                   frame_valid,
  output logic                   decode_error,
  output logic                   anode_error,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

  // sample layout: [11:8] anodes AN4..AN1, [7] DP, [6:0] {CG..CA}
  logic [11:0] pins;
  logic [11:0] sample_p0;
  logic [11:0] sample_p1;

  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic        taken;
  logic        taken_nxt;
  logic        changed;
  logic        accept;

  logic [3:0]  an_low;
  logic [1:0]  idx;
  logic        one_hot;
  logic        multi;
  logic        dp_lit;
  seg_dec_t    dec;

  logic [15:0] shadow_val;
  logic [3:0]  shadow_blank;
  logic [3:0]  shadow_dp;
  logic [3:0]  accept_mask;
  logic [15:0] shadow_val_nxt;
  logic [3:0]  shadow_blank_nxt;
  logic [3:0]  shadow_dp_nxt;
  logic [3:0]  accept_mask_nxt;
  logic        digit_ok;
  logic        frame_done;

  cap_state_t  state;
  cap_state_t  state_nxt;

  assign pins = {AN4, AN3, AN2, AN1, DP, CG, CF, CE, CD, CC, CB, CA};

  // ---- stage p0: register the pins; stage p1: previous sample for change detect
  // Input register pair used for stability comparison.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_p0 <= '0;
      sample_p1 <= '0;
    end else begin
      sample_p0 <= pins;
      sample_p1 <= sample_p0;
    end
  end

  // Stability counter; a count of 0 means no change seen since reset, so the
  // cleared sample register is never mistaken for a settled digit.
  always_comb begin
    changed = (sample_p0 != sample_p1);
    if (changed)               cnt_nxt = 8'd1;
    else if (cnt == 8'd0)      cnt_nxt = 8'd0;
    else if (cnt >= SETTLE)    cnt_nxt = SETTLE;
    else                       cnt_nxt = cnt + 8'd1;
    accept    = (cnt_nxt == SETTLE) && (changed || !taken);
    taken_nxt = (taken && !changed) || accept;
  end

  // Anode classification of the current sample.
  always_comb begin
    an_low  = ~sample_p0[11:8];
    dp_lit  = ~sample_p0[7];
    idx     = 2'd0;
    one_hot = 1'b1;
    case (an_low)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: one_hot = 1'b0;
    endcase
    multi = (an_low != 4'b0000) && !one_hot;
  end

  seven_seg_decode u_decode (
    .seg (sample_p0[6:0]),
    .dec (dec)
  );

  // Shadow update and frame-completion detection for an accepted digit.
  always_comb begin
    digit_ok         = accept && one_hot && dec.valid;
    shadow_val_nxt   = shadow_val;
    shadow_blank_nxt = shadow_blank;
    shadow_dp_nxt    = shadow_dp;
    accept_mask_nxt  = accept_mask;
    if (digit_ok) begin
      shadow_val_nxt[{idx, 2'b00} +: 4] = dec.nibble;
      shadow_blank_nxt[idx]             = dec.blank;
      shadow_dp_nxt[idx]                = dp_lit;
      accept_mask_nxt[idx]              = 1'b1;
    end
    frame_done = digit_ok && (accept_mask_nxt == 4'hF);
    if (frame_done) accept_mask_nxt = 4'h0;
  end

  // Next-state logic: COMPLETE lasts exactly the cycle after the final acceptance.
  always_comb begin
    state_nxt = COLLECT;
    if (frame_done) state_nxt = COMPLETE;
  end

  // ---- stage p1 -> state: control, shadow and output registers
  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= COLLECT;
    else        state <= state_nxt;
  end

  assign frame_valid = (state == COMPLETE);

  // Stability tracking, shadow accumulation and error pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= 8'd0;
      taken        <= 1'b0;
      shadow_val   <= '0;
      shadow_blank <= '0;
      shadow_dp    <= '0;
      accept_mask  <= '0;
      decode_error <= 1'b0;
      anode_error  <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      taken        <= taken_nxt;
      shadow_val   <= shadow_val_nxt;
      shadow_blank <= shadow_blank_nxt;
      shadow_dp    <= shadow_dp_nxt;
      accept_mask  <= accept_mask_nxt;
      decode_error <= accept && one_hot && !dec.valid;
      anode_error  <= accept && multi;
    end
  end

  // Published frame: loads the shadow (including the final digit) on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      captured_value <= '0;
      blank_mask     <= '0;
      dp_mask        <= '0;
      frame_count    <= '0;
    end else if (frame_done) begin
      captured_value <= shadow_val_nxt;
      blank_mask     <= shadow_blank_nxt;
      dp_mask        <= shadow_dp_nxt;
      frame_count    <= frame_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: table of frames plus hand-written
// sequences for settling, decode/anode errors, reset mid-frame and wrap.
module tb_seven_seg_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic [15:0] captured_value;
  logic [3:0]  blank_mask;
  logic [3:0]  dp_mask;
  logic        frame_valid;
  logic        decode_error;
  logic        anode_error;
  logic [7:0]  frame_count;

  always #5 clk = ~clk;

  seven_seg_capture #(.SETTLE_CYCLES(4), .FRAME_CNT_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .CA             (seg_n[0]),
    .CB             (seg_n[1]),
    .CC             (seg_n[2]),
    .CD             (seg_n[3]),
    .CE             (seg_n[4]),
    .CF             (seg_n[5]),
    .CG             (seg_n[6]),
    .DP             (dp_n),
    .AN1            (an_n[0]),
    .AN2            (an_n[1]),
    .AN3            (an_n[2]),
    .AN4            (an_n[3]),
    .captured_value (captured_value),
    .blank_mask     (blank_mask),
    .dp_mask        (dp_mask),
    .frame_valid    (frame_valid),
    .decode_error   (decode_error),
    .anode_error    (anode_error),
    .frame_count    (frame_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int fv_cnt   = 0;
  int de_cnt   = 0;
  int ae_cnt   = 0;

  logic [6:0] glyph [16];

  typedef struct {
    logic [15:0] val;
    logic [3:0]  blk;
    logic [3:0]  dps;
    bit          rev;
    logic [15:0] e_val;
    logic [3:0]  e_blk;
    logic [3:0]  e_dp;
  } vec_t;

  vec_t vecs [6];

  // Pulse counters, sampled on the inactive edge.
  always @(negedge clk) begin
    if (frame_valid === 1'b1)  fv_cnt++;
    if (decode_error === 1'b1) de_cnt++;
    if (anode_error === 1'b1)  ae_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    an_n  = 4'hF;
    seg_n = 7'h7F;
    dp_n  = 1'b1;
    tick(n);
  endtask

  task automatic drive(input int idx, input logic [6:0] s, input logic dp_lit);
    logic [3:0] one;
    one   = 4'b0001 << idx;
    an_n  = ~one;
    seg_n = s;
    dp_n  = ~dp_lit;
  endtask

  task automatic show(input int idx, input logic [6:0] s, input logic dp_lit, input int dwell);
    drive(idx, s, dp_lit);
    tick(dwell);
  endtask

  task automatic scan_frame(input logic [15:0] val, input logic [3:0] blk, input logic [3:0] dps,
                            input bit rev, input int dwell, input int gap);
    int d;
    logic [3:0] nib;
    for (int k = 0; k < 4; k++) begin
      d   = rev ? 3 - k : k;
      nib = val[d*4 +: 4];
      show(d, blk[d] ? 7'h7F : glyph[nib], dps[d], dwell);
      idle(gap);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fv0, de0, ae0, exp_frames;
    logic [15:0] v;

    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    vecs[0] = '{16'h270F, 4'h0, 4'h0, 1'b0, 16'h270F, 4'h0, 4'h0};
    vecs[1] = '{16'h8ACE, 4'h0, 4'h5, 1'b1, 16'h8ACE, 4'h0, 4'h5};
    vecs[2] = '{16'h1234, 4'h4, 4'h0, 1'b0, 16'h1034, 4'h4, 4'h0};
    vecs[3] = '{16'hFFFF, 4'h0, 4'hF, 1'b1, 16'hFFFF, 4'h0, 4'hF};
    vecs[4] = '{16'h5B6D, 4'hF, 4'h9, 1'b0, 16'h0000, 4'hF, 4'h9};
    vecs[5] = '{16'h5B6D, 4'h0, 4'h0, 1'b1, 16'h5B6D, 4'h0, 4'h0};

    // Reset state
    reset = 1'b0;
    idle(3);
    check("reset captured_value", captured_value, 16'h0000);
    check("reset blank_mask", blank_mask, 4'h0);
    check("reset dp_mask", dp_mask, 4'h0);
    check("reset frame_valid", frame_valid, 1'b0);
    check("reset decode_error", decode_error, 1'b0);
    check("reset anode_error", anode_error, 1'b0);
    check("reset frame_count", frame_count, 8'd0);
    reset = 1'b1;
    idle(3);

    // Dwell shorter than the settle window: nothing accepted
    fv0 = fv_cnt;
    scan_frame(16'h270F, 4'h0, 4'h0, 1'b0, 3, 2);
    idle(4);
    check("short dwell frame pulses", fv_cnt - fv0, 0);
    check("short dwell captured_value", captured_value, 16'h0000);
    check("short dwell frame_count", frame_count, 8'd0);

    // Table of full frames
    exp_frames = 0;
    foreach (vecs[i]) begin
      fv0 = fv_cnt; de0 = de_cnt; ae0 = ae_cnt;
      exp_frames++;
      scan_frame(vecs[i].val, vecs[i].blk, vecs[i].dps, vecs[i].rev, 8, 2);
      check($sformatf("vec%0d frame pulses", i), fv_cnt - fv0, 1);
      check($sformatf("vec%0d captured_value", i), captured_value, vecs[i].e_val);
      check($sformatf("vec%0d blank_mask", i), blank_mask, vecs[i].e_blk);
      check($sformatf("vec%0d dp_mask", i), dp_mask, vecs[i].e_dp);
      check($sformatf("vec%0d frame_count", i), frame_count, exp_frames);
      check($sformatf("vec%0d error pulses", i), (de_cnt - de0) + (ae_cnt - ae0), 0);
    end

    // Decode error on digit 2, re-acceptance of digit 0, then exact latency
    fv0 = fv_cnt; de0 = de_cnt;
    show(0, glyph[5], 1'b0, 8); idle(2);
    show(0, glyph[1], 1'b0, 8); idle(2);
    show(1, glyph[2], 1'b0, 8); idle(2);
    show(3, glyph[4], 1'b0, 8); idle(2);
    show(2, 7'h7E, 1'b0, 8);    idle(2);
    check("bad glyph decode_error pulses", de_cnt - de0, 1);
    check("bad glyph frame pulses", fv_cnt - fv0, 0);
    drive(2, glyph[9], 1'b0);
    tick(4);
    check("latency frame_valid before", frame_valid, 1'b0);
    tick(1);
    check("latency frame_valid at S+1", frame_valid, 1'b1);
    tick(1);
    check("latency frame_valid after", frame_valid, 1'b0);
    tick(2); idle(2);
    exp_frames++;
    check("rescan captured_value", captured_value, 16'h4921);
    check("rescan frame pulses", fv_cnt - fv0, 1);
    check("rescan frame_count", frame_count, exp_frames);

    // Two anodes low mid-frame: error pulse, mask untouched
    fv0 = fv_cnt; ae0 = ae_cnt;
    show(0, glyph[10], 1'b0, 8); idle(2);
    show(1, glyph[11], 1'b0, 8); idle(2);
    show(2, glyph[12], 1'b0, 8); idle(2);
    an_n = 4'b1010; seg_n = glyph[8]; dp_n = 1'b1;
    tick(6);
    idle(2);
    check("dual anode anode_error pulses", ae_cnt - ae0, 1);
    check("dual anode frame pulses", fv_cnt - fv0, 0);
    show(3, glyph[13], 1'b0, 8); idle(2);
    exp_frames++;
    check("after dual anode frame pulses", fv_cnt - fv0, 1);
    check("after dual anode captured_value", captured_value, 16'hDCBA);
    check("after dual anode frame_count", frame_count, exp_frames);

    // Reset mid-frame discards the partial frame
    show(0, glyph[7], 1'b0, 8); idle(2);
    show(1, glyph[7], 1'b0, 8); idle(2);
    reset = 1'b0;
    tick(5);
    check("mid reset captured_value", captured_value, 16'h0000);
    check("mid reset frame_count", frame_count, 8'd0);
    reset = 1'b1;
    idle(3);
    fv0 = fv_cnt;
    show(3, 7'h7F, 1'b0, 8);    idle(2);
    show(2, glyph[3], 1'b0, 8); idle(2);
    check("partial discarded frame pulses", fv_cnt - fv0, 0);
    show(1, glyph[15], 1'b1, 8); idle(2);
    show(0, glyph[2], 1'b0, 8);  idle(2);
    check("post reset frame pulses", fv_cnt - fv0, 1);
    check("post reset captured_value", captured_value, 16'h03F2);
    check("post reset blank_mask", blank_mask, 4'b1000);
    check("post reset dp_mask", dp_mask, 4'b0010);
    check("post reset frame_count", frame_count, 8'd1);

    // 256 frames: frame_count wraps to 0
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    idle(3);
    fv0 = fv_cnt;
    for (int i = 0; i < 256; i++) begin
      v = 16'(i * 257);
      scan_frame(v, 4'h0, 4'h0, 1'b0, 5, 1);
      if (i == 254) check("wrap frame_count at 255", frame_count, 8'd255);
    end
    idle(2);
    check("wrap frame pulses", fv_cnt - fv0, 256);
    check("wrap frame_count", frame_count, 8'd0);
    check("wrap captured_value", captured_value, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
- Receiving end of the multiplexed seven-segment display interface driven by the lab top level (CA..CG, DP, AN1..AN4).
- Watches the scanned anode/segment lines and decodes each stable digit back to a hex nibble.
- Assembles complete 4-digit frames into a 16-bit word for self-check, loopback or bench scoreboarding.
- Sits on the same clock as the display driver; its inputs are the driver's pin-level outputs.

Parameters:
SETTLE_CYCLES, 4, consecutive identical samples required before a digit is accepted (legal range 1..255)
FRAME_CNT_W, 8, width of frame_count

Ports:
clk  input  1  system clock (100 MHz)
reset  input  1  asynchronous, active-low reset
CA, CB, CC, CD, CE, CF, CG  input  1 each  segment lines a..g, active-low
DP  input  1  decimal point, active-low
AN1, AN2, AN3, AN4  input  1 each  digit anodes, active-low; AN1 = digit 0 (bits 3:0), AN4 = digit 3 (bits 15:12)
captured_value  output  16  last complete frame, digit n in bits [4n+3:4n]
blank_mask  output  4  bit n set when digit n was blank (all segments off) in the last frame
dp_mask  output  4  bit n set when DP was lit on digit n in the last frame
frame_valid  output  1  one-cycle pulse when captured_value/blank_mask/dp_mask update
decode_error  output  1  one-cycle pulse on acceptance of an undecodable segment pattern
anode_error  output  1  one-cycle pulse when more than one anode is low for SETTLE_CYCLES cycles
frame_count  output  FRAME_CNT_W  completed frames since reset; wraps modulo 2^FRAME_CNT_W

Behaviour:
- Reset (reset = 0, async):
  - All outputs are 0; captured_value = 16'h0000; frame_count = 0.
  - Sample register, stability counter, accept mask, taken flag and shadow registers are all cleared.
- Input stage:
  - All 12 inputs are registered once per clock into `sample`.
  - Segment vector seg[6:0] = {CG,CF,CE,CD,CC,CB,CA}.
- Stability counter:
  - Increments, saturating at SETTLE_CYCLES, while `sample` equals its value from the previous cycle.
  - Reloads to 1 on any change.
  - A `taken` flag clears on any change.
- Acceptance:
  - Occurs on the edge where the counter reaches SETTLE_CYCLES and `taken` is 0; that edge also sets `taken`.
  - Each anode dwell is therefore accepted at most once.
- Anode classification of the accepted sample:
  - No anode low: ignored (inter-digit blanking), no flags.
  - Exactly one anode low: digit index n = 0..3.
  - Two or more anodes low: anode_error pulses; nothing else changes.
- Segment decode (active-low hex table, see package):
  - Recognised glyphs 0-F: shadow nibble[n] = value, shadow blank[n] = 0.
  - seg = 7'h7F: shadow nibble[n] = 0, blank[n] = 1.
  - Any other pattern: decode_error pulses; digit is not accepted and the mask bit stays clear.
  - shadow dp[n] = ~DP.
  - accept_mask[n] is set on every successful acceptance.
- Re-acceptance of a digit already in the mask overwrites its shadow value and does not complete the frame.
- State machine:
  - COLLECT: normal accumulation.
  - COMPLETE: entered for exactly one cycle when an acceptance makes accept_mask = 4'hF.
  - COMPLETE is registered on the same edge as that acceptance. On that edge:
    - captured_value, blank_mask and dp_mask load the shadow, including the digit just accepted.
    - frame_valid = 1 and frame_count increments.
    - accept_mask clears.
  - The next cycle returns to COLLECT with frame_valid = 0.
- Latency: frame_valid asserts SETTLE_CYCLES+1 edges after the final digit's pattern first appears on the pins.
- Scan order: any order is legal; frames are completion-based, not order-based.
- Outputs hold between frames.
- Reset mid-frame discards partial frames completely.
- SETTLE_CYCLES = 1: every changed sample is accepted on its first registered cycle.

Decomposition:
- Package seven_seg_pkg:
  - SEG_BLANK = 7'h7F.
  - Active-low glyph constants: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
  - typedef for capture state {COLLECT, COMPLETE}.
  - Function seg_to_hex returning {valid, blank, nibble}.
- The display driver must import the same table, so encode and decode stay consistent.
- One sub-module, seven_seg_decode (combinational seg -> {valid, blank, nibble}); everything else stays in the top module.

Test Plan:
- Reset, then scan 16'h270F: AN1..AN4 in turn, dwell 8 clk each, 2 clk blanking, SETTLE_CYCLES=4 -> single frame_valid pulse, captured_value=16'h270F, blank_mask=0, frame_count=1.
- Dwell of 3 clk per digit -> no acceptance, no frame_valid, captured_value stays 16'h0000.
- Digit 2 driven with seg=7'h7E, others valid -> decode_error pulses once, no frame until digit 2 is rescanned with a valid glyph.
- AN1 and AN3 both low for 6 clk -> anode_error pulses once, accept_mask unchanged.
- Accept digits 0 and 1, assert reset low for 5 clk, then scan 16'h03F2 with digit 3 blank and DP lit on digit 1 -> captured_value=16'h03F2 with nibble3=0, blank_mask=4'b1000, dp_mask=4'b0010, frame_count=1.
- 256 consecutive frames -> frame_count wraps to 0, frame_valid pulses 256 times.
